// File: rtl/rc5_pkg.sv
// Shared RC5-8 definitions for the 16-bit block encryptor and decryptor:
// word geometry, round count, expanded key table, rotate helpers and FSM states.
package rc5_pkg;

    localparam int RC5_W      = 8;
    localparam int RC5_LGW    = 3;
    localparam int RC5_ROUNDS = 12;
    localparam int RC5_T      = 2 * RC5_ROUNDS + 2;

    localparam logic [RC5_W-1:0] RC5_P = 8'hB7;
    localparam logic [RC5_W-1:0] RC5_Q = 8'h9F;

    typedef logic [RC5_T-1:0][RC5_W-1:0] s_table_t;

    // Expanded key table: magic-constant progression S[k] = P + k*Q mod 2^8.
    function automatic s_table_t gen_s();
        s_table_t t;
        t[0] = RC5_P;
        for (int k = 1; k < RC5_T; k++) begin
            t[k] = t[k-1] + RC5_Q;
        end
        return t;
    endfunction

    localparam s_table_t S = gen_s();

    function automatic logic [RC5_W-1:0] rotl8(input logic [RC5_W-1:0] x,
                                               input logic [RC5_LGW-1:0] amt);
        logic [2*RC5_W-1:0] t;
        t = {x, x} << amt;
        return t[2*RC5_W-1:RC5_W];
    endfunction

    function automatic logic [RC5_W-1:0] rotr8(input logic [RC5_W-1:0] x,
                                               input logic [RC5_LGW-1:0] amt);
        logic [2*RC5_W-1:0] t;
        t = {x, x} >> amt;
        return t[RC5_W-1:0];
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } rc5_state_e;

endpackage

// File: rtl/rc5_dec_round.sv
// One combinational RC5-8 decryption round: undoes the B half first, then A.
module rc5_dec_round
    import rc5_pkg::*;
(
    input  logic [RC5_W-1:0] a,
    input  logic [RC5_W-1:0] b,
    input  logic [RC5_W-1:0] s_even,
    input  logic [RC5_W-1:0] s_odd,
    output logic [RC5_W-1:0] a_next,
    output logic [RC5_W-1:0] b_next
);

    logic [RC5_W-1:0] b_diff;
    logic [RC5_W-1:0] a_diff;

    always_comb begin
        b_diff = b - s_odd;
        b_next = rotr8(b_diff, a[RC5_LGW-1:0]) ^ a;
        a_diff = a - s_even;
        a_next = rotr8(a_diff, b_next[RC5_LGW-1:0]) ^ b_next;
    end

endmodule

// File: rtl/rc5_dec_16bit.sv
// RC5-8/R block decryptor for 16-bit blocks, one round per clock.
// Ciphertext is latched at start; plaintext and done are held until start drops.
module rc5_dec_16bit
    import rc5_pkg::*;
#(
    parameter int ROUNDS = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_start,
    input  logic [15:0] c,
    output logic [15:0] p,
    output logic        dec_done
);

    localparam int CW = $clog2(ROUNDS + 1);

    if (ROUNDS != RC5_ROUNDS) begin : g_rounds_mismatch
        $error("rc5_dec_16bit: ROUNDS must equal rc5_pkg::RC5_ROUNDS");
    end

    rc5_state_e       state_q, state_d;
    logic [CW-1:0]    i_q, i_d;
    logic [RC5_W-1:0] a_q, a_d;
    logic [RC5_W-1:0] b_q, b_d;
    logic [15:0]      p_q, p_d;
    logic             done_q, done_d;

    logic [RC5_W-1:0] s_even, s_odd;
    logic [RC5_W-1:0] a_rnd, b_rnd;
    logic [RC5_W-1:0] a_fin, b_fin;

    always_comb begin
        s_even = S[{i_q, 1'b0}];
        s_odd  = S[{i_q, 1'b1}];
    end

    rc5_dec_round u_round (
        .a      (a_q),
        .b      (b_q),
        .s_even (s_even),
        .s_odd  (s_odd),
        .a_next (a_rnd),
        .b_next (b_rnd)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        done_d  = done_q;
        b_fin   = b_q - S[1];
        a_fin   = a_q - S[0];

        unique case (state_q)
            ST_IDLE: begin
                if (dec_start) begin
                    a_d     = c[7:0];
                    b_d     = c[15:8];
                    i_d     = CW'(ROUNDS);
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                a_d = a_rnd;
                b_d = b_rnd;
                i_d = i_q - 1'b1;
                if (i_q == CW'(1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                a_d     = a_fin;
                b_d     = b_fin;
                p_d     = {b_fin, a_fin};
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Level-sensitive start: a new request needs start to fall first.
                if (!dec_start) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign p        = p_q;
    assign dec_done = done_q;

endmodule
